// File: rtl/hex_led_scan_if.sv
// hex_led_scan_if: bus between a register block (master) and the
// hex_led_scan display driver (slave).
//   num        hex word, leftmost digit in the top nibble
//   dp         decimal point per digit, 1 = lit
//   bright     brightness level, 0 = dimmest, all-ones = full
//   enable     1 = scan, 0 = display dark
//   anodes     active-low digit selects, MSB = leftmost digit
//   cathodes   active-low {a,b,c,d,e,f,g,dp}
//   frame_done one-clock pulse at the end of each frame
// DIGITS and BRIGHT_W must match the parameters of the attached driver.
interface hex_led_scan_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 3
);
    logic [4*DIGITS-1:0]  num;
    logic [DIGITS-1:0]    dp;
    logic [BRIGHT_W-1:0]  bright;
    logic                 enable;
    logic [DIGITS-1:0]    anodes;
    logic [7:0]           cathodes;
    logic                 frame_done;

    modport master (
        output num, dp, bright, enable,
        input  anodes, cathodes, frame_done
    );

    modport slave (
        input  num, dp, bright, enable,
        output anodes, cathodes, frame_done
    );
endinterface

// File: rtl/hex_led_scan.sv
// hex_led_scan: multiplexed common-anode seven-segment hex display driver.
// Scans DIGITS digits leftmost first, one slot of 2^SLOT_LOG2 clocks per
// digit. Inputs are captured once per frame so a frame never mixes old and
// new data. Each slot starts with GUARD blank clocks (anti-ghosting) and the
// anode on-time is trimmed by a PWM compare against the brightness level.
//
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  hex_led_scan_if.slave (num, dp, bright, enable in;
//        anodes, cathodes, frame_done out; all outputs registered)
//
// Optional build macro: HEX_LED_SCAN_LZB_EN enables leading-zero blanking
// (digit i > 0 loses its segments when it and every digit to its left are 0).
module hex_led_scan #(
    parameter int DIGITS    = 4,
    parameter int SLOT_LOG2 = 10,
    parameter int BRIGHT_W  = 3,
    parameter int GUARD     = 2
) (
    input  logic          clk,
    input  logic          rst,
    hex_led_scan_if.slave bus
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [SLOT_LOG2-1:0] GUARD_CNT = SLOT_LOG2'(GUARD);

    logic [SLOT_LOG2-1:0]  r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*DIGITS-1:0]   r_sh_num;
    logic [DIGITS-1:0]     r_sh_dp;
    logic [BRIGHT_W-1:0]   r_sh_bright;
    logic [DIGITS-1:0]     r_anodes;
    logic [7:0]            r_cathodes;
    logic                  r_frame_done;

    logic                  w_capture;
    logic [4*DIGITS-1:0]   w_num;
    logic [DIGITS-1:0]     w_dp;
    logic [BRIGHT_W-1:0]   w_bright;
    logic [3:0]            w_digit;
    logic [DIGITS-1:0]     w_blank_mask;
    logic                  w_zero_run;
    logic [6:0]            w_seg;
    logic                  w_lit;
    logic [DIGITS-1:0]     w_anodes;
    logic                  w_cnt_last;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_comb begin
        // The capture clock also renders the first clock of the frame, so
        // it uses the incoming values rather than the stale shadows.
        w_capture  = bus.enable && (r_cnt == '0) && (r_idx == LAST_IDX);
        w_num      = w_capture ? bus.num    : r_sh_num;
        w_dp       = w_capture ? bus.dp     : r_sh_dp;
        w_bright   = w_capture ? bus.bright : r_sh_bright;
        w_digit    = w_num[{r_idx, 2'b00} +: 4];
        w_cnt_last = (r_cnt == '1);

        w_blank_mask = '0;
        w_zero_run   = 1'b1;
`ifdef HEX_LED_SCAN_LZB_EN
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_zero_run = w_zero_run && (w_num[4*(DIGITS-1-k) +: 4] == 4'h0);
            w_blank_mask[DIGITS-1-k] = w_zero_run && (k != DIGITS - 1);
        end
`endif
        w_seg = w_blank_mask[r_idx] ? 7'b0000000 : hex_seg(w_digit);

        // PWM: top BRIGHT_W bits of the slot counter against brightness.
        w_lit = (r_cnt >= GUARD_CNT) &&
                (r_cnt[SLOT_LOG2-1 -: BRIGHT_W] <= w_bright);
        w_anodes = '1;
        if (w_lit) begin
            w_anodes[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= LAST_IDX;
            r_sh_num     <= '0;
            r_sh_dp      <= '0;
            r_sh_bright  <= '0;
            r_anodes     <= '1;
            r_cathodes   <= '1;
            r_frame_done <= 1'b0;
        end else if (!bus.enable) begin
            r_cnt        <= '0;
            r_idx        <= LAST_IDX;
            r_anodes     <= '1;
            r_cathodes   <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= r_cnt + SLOT_LOG2'(1);
            if (w_cnt_last) begin
                r_idx <= (r_idx == '0) ? LAST_IDX : r_idx - IDX_W'(1);
            end
            if (w_capture) begin
                r_sh_num    <= bus.num;
                r_sh_dp     <= bus.dp;
                r_sh_bright <= bus.bright;
            end
            r_anodes     <= w_anodes;
            r_cathodes   <= ~{w_seg, w_dp[r_idx]};
            r_frame_done <= (r_idx == '0) && w_cnt_last;
        end
    end

    assign bus.anodes     = r_anodes;
    assign bus.cathodes   = r_cathodes;
    assign bus.frame_done = r_frame_done;

endmodule
